// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds 10-bit symbol alignment via control tokens and
// deserializer bitslip, then decodes aligned words into video bytes or control bits.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT    = 16,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SLIP_WAIT     = 4,
    parameter int LOSS_WINDOW   = 1 << 20
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic [9:0] raw_word,
    output logic       bitslip,
    output logic [3:0] slip_count,
    output logic       locked,
    output logic       de,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out
);

    localparam int RUN_W  = (LOCK_COUNT    > 1) ? $clog2(LOCK_COUNT)    : 1;
    localparam int WIN_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
    localparam int WAIT_W = (SLIP_WAIT     > 1) ? $clog2(SLIP_WAIT)     : 1;
    localparam int LOSS_W = (LOSS_WINDOW   > 1) ? $clog2(LOSS_WINDOW)   : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP_WAIT,
        ST_LOCKED
    } state_t;

    state_t            state_q;
    logic [RUN_W-1:0]  run_cnt_q;
    logic [WIN_W-1:0]  win_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [LOSS_W-1:0] loss_cnt_q;
    logic              bitslip_q;
    logic [3:0]        slip_q;
    logic              locked_q;
    logic              de_q;
    logic [7:0]        data_q;
    logic [1:0]        ctrl_q;

    logic              is_token_d;
    logic [1:0]        token_d;
    logic [7:0]        inv_d;
    logic [7:0]        video_d;

    // NOTE: every signal written here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        is_token_d = 1'b1;
        token_d    = 2'b00;
        case (raw_word)
            10'h354: token_d = 2'b00;
            10'h0AB: token_d = 2'b01;
            10'h154: token_d = 2'b10;
            10'h2AB: token_d = 2'b11;
            default: is_token_d = 1'b0;
        endcase
    end

    // bit9 marks an inverted payload, bit8 selects XOR (1) or XNOR (0) chaining.
    always_comb begin
        inv_d      = raw_word[9] ? ~raw_word[7:0] : raw_word[7:0];
        video_d    = 8'h00;
        video_d[0] = inv_d[0];
        for (int i = 1; i < 8; i++) begin
            video_d[i] = raw_word[8] ? (inv_d[i] ^ inv_d[i-1]) : ~(inv_d[i] ^ inv_d[i-1]);
        end
    end

    // NOTE: all state, including outputs, updates with non-blocking assignments so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SEARCH;
            run_cnt_q  <= '0;
            win_cnt_q  <= '0;
            wait_cnt_q <= '0;
            loss_cnt_q <= '0;
            bitslip_q  <= 1'b0;
            slip_q     <= 4'd0;
            locked_q   <= 1'b0;
            de_q       <= 1'b0;
            data_q     <= 8'h00;
            ctrl_q     <= 2'b00;
        end else begin
            bitslip_q <= 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    if (is_token_d && run_cnt_q == RUN_LAST) begin
                        // Lock beats a simultaneous window expiry; the locking token is decoded.
                        state_q    <= ST_LOCKED;
                        locked_q   <= 1'b1;
                        ctrl_q     <= token_d;
                        de_q       <= 1'b0;
                        data_q     <= 8'h00;
                        loss_cnt_q <= '0;
                        run_cnt_q  <= '0;
                        win_cnt_q  <= '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        bitslip_q  <= 1'b1;
                        slip_q     <= (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
                        wait_cnt_q <= '0;
                        state_q    <= ST_SLIP_WAIT;
                    end else begin
                        win_cnt_q <= win_cnt_q + WIN_W'(1);
                        run_cnt_q <= is_token_d ? run_cnt_q + RUN_W'(1) : '0;
                    end
                end
                ST_SLIP_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= ST_SEARCH;
                        win_cnt_q  <= '0;
                        run_cnt_q  <= '0;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (is_token_d) begin
                        loss_cnt_q <= '0;
                        de_q       <= 1'b0;
                        data_q     <= 8'h00;
                        ctrl_q     <= token_d;
                    end else if (loss_cnt_q == LOSS_LAST) begin
                        state_q    <= ST_SEARCH;
                        locked_q   <= 1'b0;
                        de_q       <= 1'b0;
                        data_q     <= 8'h00;
                        ctrl_q     <= 2'b00;
                        loss_cnt_q <= '0;
                        win_cnt_q  <= '0;
                        run_cnt_q  <= '0;
                    end else begin
                        loss_cnt_q <= loss_cnt_q + LOSS_W'(1);
                        de_q       <= 1'b1;
                        data_q     <= video_d;
                    end
                end
                default: state_q <= ST_SEARCH;
            endcase
        end
    end

    assign bitslip    = bitslip_q;
    assign slip_count = slip_q;
    assign locked     = locked_q;
    assign de         = de_q;
    assign data_out   = data_q;
    assign ctrl_out   = ctrl_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: the driver queues expected outputs per
// cycle, an independent monitor pops and compares them against the DUT.
module tb_tmds_channel_decoder;

    localparam int LOCK_COUNT    = 4;
    localparam int SEARCH_WINDOW = 32;
    localparam int SLIP_WAIT     = 3;
    localparam int LOSS_WINDOW   = 64;
    localparam int SPACING       = SEARCH_WINDOW + SLIP_WAIT;

    logic       pixel_clk = 1'b0;
    logic       rst_n     = 1'b0;
    logic [9:0] raw_word  = 10'h000;
    logic       bitslip;
    logic [3:0] slip_count;
    logic       locked;
    logic       de;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;

    tmds_channel_decoder #(
        .LOCK_COUNT   (LOCK_COUNT),
        .SEARCH_WINDOW(SEARCH_WINDOW),
        .SLIP_WAIT    (SLIP_WAIT),
        .LOSS_WINDOW  (LOSS_WINDOW)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .raw_word  (raw_word),
        .bitslip   (bitslip),
        .slip_count(slip_count),
        .locked    (locked),
        .de        (de),
        .data_out  (data_out),
        .ctrl_out  (ctrl_out)
    );

    always #5 pixel_clk = ~pixel_clk;

    int cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    // Expected output vector: {bitslip, slip_count, locked, de, data_out, ctrl_out}
    typedef struct {
        int          at_cyc;
        bit          half;
        string       name;
        logic [16:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [16:0] mk(logic bs, logic [3:0] sc, logic lk, logic de_e,
                                       logic [7:0] dat, logic [1:0] ctl);
        return {bs, sc, lk, de_e, dat, ctl};
    endfunction

    function automatic string fmt(logic [16:0] v);
        return $sformatf("bitslip=%b slip=%0d locked=%b de=%b data=%h ctrl=%b",
                         v[16], v[15:12], v[11], v[10], v[9:2], v[1:0]);
    endfunction

    // Expected outputs while searching: m = word index since SEARCH was entered from reset/loss.
    function automatic logic [16:0] exp_search(int m, int slip0);
        int   p;
        logic bs;
        p  = (m < SEARCH_WINDOW) ? 0 : 1 + (m - SEARCH_WINDOW) / SPACING;
        bs = (m >= SEARCH_WINDOW) && ((m - SEARCH_WINDOW) % SPACING == 0);
        return mk(bs, 4'((slip0 + p) % 10), 1'b0, 1'b0, 8'h00, 2'b00);
    endfunction

    function automatic logic [9:0] rotl(logic [9:0] v, int n);
        logic [9:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
        return r;
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got {%s} expected {%s}", name, cyc, fmt(act), fmt(exp));
        end
    endtask

    task automatic push(input string name, input logic [16:0] e, input int at, input bit half);
        exp_t t;
        t.at_cyc = at;
        t.half   = half;
        t.name   = name;
        t.exp    = e;
        sb_q.push_back(t);
    endtask

    task automatic drain(input bit half);
        exp_t t;
        int   now;
        now = cyc * 2 + int'(half);
        while (sb_q.size() > 0 && (sb_q[0].at_cyc * 2 + int'(sb_q[0].half)) <= now) begin
            t = sb_q.pop_front();
            if (t.at_cyc * 2 + int'(t.half) == now) begin
                check(t.name, {bitslip, slip_count, locked, de, data_out, ctrl_out}, t.exp);
            end else begin
                checks++;
                errors++;
                $display("FAIL %s: sample slot cyc %0d passed without comparison", t.name, t.at_cyc);
            end
        end
    endtask

    // Monitor: samples 1 time unit after each clock edge.
    initial begin
        forever begin
            @(posedge pixel_clk);
            #1 drain(1'b0);
            @(negedge pixel_clk);
            #1 drain(1'b1);
        end
    end

    // Drive one word; its decoded effect is visible one cycle later.
    task automatic step(input logic [9:0] w, input string name, input logic [16:0] e);
        push(name, e, cyc + 1, 1'b0);
        raw_word = w;
        @(posedge pixel_clk);
        #1;
    endtask

    // Asynchronous reset: outputs must clear before the next clock edge.
    task automatic reset_pulse(input string name);
        #1 rst_n = 1'b0;
        push(name, mk(1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 2'b00), cyc, 1'b1);
        @(posedge pixel_clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [9:0]  word;
        logic [16:0] exp;
    } vec_t;

    initial begin
        logic [16:0] zero;
        vec_t        dec_vec[8];
        int          rot;

        zero = mk(1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 2'b00);
        @(posedge pixel_clk);
        #1;

        // Reset held: outputs stay cleared regardless of input.
        for (int i = 0; i < 3; i++) step(10'($urandom), "reset_hold", zero);

        // Aligned tokens: lock after the 4th.
        rst_n = 1'b1;
        for (int i = 0; i < LOCK_COUNT - 1; i++) step(10'h354, "lock_run", zero);
        step(10'h354, "lock_declared", mk(1'b0, 4'd0, 1'b1, 1'b0, 8'h00, 2'b00));

        // Misaligned stream by 3 bits; the deserializer model rotates back 1 bit per pulse.
        reset_pulse("reset_when_locked");
        rot = 3;
        for (int m = 1; m <= 3 * SPACING + LOCK_COUNT; m++) begin
            step(rotl(10'h354, rot), "slip_search",
                 (m == 3 * SPACING + LOCK_COUNT) ? mk(1'b0, 4'd3, 1'b1, 1'b0, 8'h00, 2'b00)
                                                 : exp_search(m, 0));
            if (bitslip === 1'b1) rot = (rot == 0) ? 9 : rot - 1;
        end

        // Decode while locked.
        dec_vec[0] = '{10'h1FF, mk(1'b0, 4'd3, 1'b1, 1'b1, 8'h01, 2'b00)};
        dec_vec[1] = '{10'h100, mk(1'b0, 4'd3, 1'b1, 1'b1, 8'h00, 2'b00)};
        dec_vec[2] = '{10'h2AB, mk(1'b0, 4'd3, 1'b1, 1'b0, 8'h00, 2'b11)};
        dec_vec[3] = '{10'h2FF, mk(1'b0, 4'd3, 1'b1, 1'b1, 8'hFE, 2'b11)};
        dec_vec[4] = '{10'h3A5, mk(1'b0, 4'd3, 1'b1, 1'b1, 8'hEE, 2'b11)};
        dec_vec[5] = '{10'h154, mk(1'b0, 4'd3, 1'b1, 1'b0, 8'h00, 2'b10)};
        dec_vec[6] = '{10'h1F0, mk(1'b0, 4'd3, 1'b1, 1'b1, 8'h10, 2'b10)};
        dec_vec[7] = '{10'h0AB, mk(1'b0, 4'd3, 1'b1, 1'b0, 8'h00, 2'b01)};
        foreach (dec_vec[i]) step(dec_vec[i].word, $sformatf("decode_%0d", i), dec_vec[i].exp);

        // Loss of lock after LOSS_WINDOW words without a token; slip_count is held.
        for (int n = 1; n <= LOSS_WINDOW; n++) begin
            step(10'h1FF, "loss_window",
                 (n < LOSS_WINDOW) ? mk(1'b0, 4'd3, 1'b1, 1'b1, 8'h01, 2'b01)
                                   : mk(1'b0, 4'd3, 1'b0, 1'b0, 8'h00, 2'b00));
        end

        // Search restarts with a fresh window; second slip lands on slip_count=5.
        for (int m = 1; m <= SPACING + SEARCH_WINDOW; m++) begin
            step(10'h1FF, "resume_search", exp_search(m, 3));
        end

        // Reset while the bitslip pulse is active in SLIP_WAIT.
        reset_pulse("reset_in_slip_wait");

        // Lock completing on the window's last cycle must not slip.
        for (int m = 1; m <= SEARCH_WINDOW; m++) begin
            step((m > SEARCH_WINDOW - LOCK_COUNT) ? 10'h354 : 10'h1FF, "lock_vs_window",
                 (m == SEARCH_WINDOW) ? mk(1'b0, 4'd0, 1'b1, 1'b0, 8'h00, 2'b00)
                                      : exp_search(m, 0));
        end

        // Ten slips without a token: slip_count runs 1..9 then wraps to 0.
        reset_pulse("reset_before_wrap");
        for (int m = 1; m <= SEARCH_WINDOW + 9 * SPACING; m++) begin
            step(10'h1FF, "slip_wrap", exp_search(m, 0));
        end

        repeat (4) @(posedge pixel_clk);
        #2;
        while (sb_q.size() > 0) begin
            exp_t t;
            t = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cyc %0d never compared", t.name, t.at_cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
